// File: rtl/vanilla_pkg.sv
// vanilla_pkg: shared arbiter state type and round-robin pick helper.
// Also provides the io_map.svh bus widths when that header has not already defined them.
`default_nettype none

`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vanilla_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Returns the index of the winning master; on a tie the one not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: two-master WISHBONE bus bundle plus the shared slave side.
// slave = arbiter view, master = view of the masters and the downstream slave.
`default_nettype none

interface wb_arbiter_if;
    logic [1:0]                            m_cyc;
    logic [1:0]                            m_stb;
    logic [1:0]                            m_we;
    logic [1:0][`MMIO_ADDR_WIDTH-1:0]      m_addr;
    logic [1:0][`DATA_WIDTH-1:0]           m_dat_w;
    logic [`DATA_WIDTH-1:0]                m_dat_r;
    logic [1:0]                            m_ack;

    logic                                  CYC_O;
    logic                                  STB_O;
    logic                                  WE_O;
    logic [`MMIO_ADDR_WIDTH-1:0]           ADDR_O;
    logic [`DATA_WIDTH-1:0]                DAT_O;
    logic [`DATA_WIDTH-1:0]                DAT_I;
    logic                                  ACK_I;

    modport slave (
        input  m_cyc, m_stb, m_we, m_addr, m_dat_w, DAT_I, ACK_I,
        output m_dat_r, m_ack, CYC_O, STB_O, WE_O, ADDR_O, DAT_O
    );

    modport master (
        output m_cyc, m_stb, m_we, m_addr, m_dat_w, DAT_I, ACK_I,
        input  m_dat_r, m_ack, CYC_O, STB_O, WE_O, ADDR_O, DAT_O
    );
endinterface

`default_nettype wire

// File: rtl/wb_watchdog.sv
// wb_watchdog: stall counter that forces a termination ack after TIMEOUT_CYCLES.
// Only compiled when WB_ARB_TIMEOUT_EN is defined.
`default_nettype none

`ifdef WB_ARB_TIMEOUT_EN
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire  logic clk,
    input  wire  logic reset_n,
    input  wire  logic busy,
    input  wire  logic stb,
    input  wire  logic ack,
    input  wire  logic err_clr,
    output logic       fire,
    output logic       err_flag
);
    logic [15:0] count;
    logic        stall;

    assign stall = busy & stb & ~ack;
    // count holds completed stall cycles, so the Nth stall cycle sees N-1
    assign fire  = stall & (count == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            err_flag <= 1'b0;
        end else begin
            if (!busy || ack || fire) begin
                count <= '0;
            end else if (stall) begin
                count <= count + 16'd1;
            end
            if (fire) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end
endmodule
`endif

`default_nettype wire

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin WISHBONE arbiter with bus lock via m_cyc.
// Optional watchdog enabled by macro WB_ARB_TIMEOUT_EN.
`default_nettype none

module wb_arbiter
    import vanilla_pkg::*;
#(
    parameter int unsigned             TIMEOUT_CYCLES = 255,
    parameter logic [`DATA_WIDTH-1:0]  ERR_DATA       = 32'hDEAD_BEEF
) (
    input  wire  logic       clk,
    input  wire  logic       reset_n,
    wb_arbiter_if.slave      bus,
    output logic [1:0]       grant,
    output logic             err_flag,
    input  wire  logic       err_clr
);
    arb_state_t state;
    logic       last_grant;
    logic       owner;
    logic       busy;
    logic       winner;
    logic       fire;

    assign busy   = (state == BUSY);
    assign owner  = grant[1];
    assign winner = rr_pick(bus.m_cyc, last_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_cyc) begin
                        state <= BUSY;
                        grant <= winner ? 2'b10 : 2'b01;
                    end
                end
                BUSY: begin
                    // Ownership lasts exactly as long as the owner holds m_cyc.
                    if (!bus.m_cyc[owner]) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_grant <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CYC_O   = busy & bus.m_cyc[owner];
    assign bus.STB_O   = bus.CYC_O & bus.m_stb[owner];
    assign bus.WE_O    = bus.CYC_O & bus.m_we[owner];
    assign bus.ADDR_O  = busy ? bus.m_addr[owner]  : '0;
    assign bus.DAT_O   = busy ? bus.m_dat_w[owner] : '0;
    assign bus.m_ack   = (busy && (bus.ACK_I || fire)) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.m_dat_r = fire ? ERR_DATA : bus.DAT_I;

`ifdef WB_ARB_TIMEOUT_EN
    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .busy     (busy),
        .stb      (bus.STB_O),
        .ack      (bus.ACK_I),
        .err_clr  (err_clr),
        .fire     (fire),
        .err_flag (err_flag)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign fire           = 1'b0;
    assign err_flag       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning strobe cycles without ACK_I before the watchdog fires (range 2..65535).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, meaning read data returned on a watchdog-terminated cycle.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port m_cyc  input  [1:0]  meaning per-master bus request and lock; m_cyc[0] is the MCS bridge.
REQ-006 SHALL have port m_stb  input  [1:0]  meaning per-master strobe.
REQ-007 SHALL have port m_we  input  [1:0]  meaning per-master write enable.
REQ-008 SHALL have port m_addr  input  [1:0][`MMIO_ADDR_WIDTH-1:0]  meaning per-master word address.
REQ-009 SHALL have port m_dat_w  input  [1:0][`DATA_WIDTH-1:0]  meaning per-master write data.
REQ-010 SHALL have port m_dat_r  output  [`DATA_WIDTH-1:0]  meaning read data, common to both masters.
REQ-011 SHALL have port m_ack  output  [1:0]  meaning per-master acknowledge.
REQ-012 SHALL have ports CYC_O, STB_O, WE_O (output, 1 each), ADDR_O (output, `MMIO_ADDR_WIDTH), DAT_O (output, `DATA_WIDTH), DAT_I (input, `DATA_WIDTH) and ACK_I (input, 1), meaning the WISHBONE slave side.
REQ-013 SHALL have port grant  output  [1:0]  meaning one-hot current owner, 00 when idle.
REQ-014 SHALL have port err_flag  output  1  meaning sticky watchdog-fired indication.
REQ-015 SHALL have port err_clr  input  1  meaning synchronous clear of err_flag.

Function
REQ-016 SHALL implement a 2-state FSM: IDLE and BUSY.
REQ-017 In IDLE, any asserted m_cyc SHALL cause grant to be registered and the FSM to move to BUSY; CYC_O rises on the next cycle (1-cycle arbitration latency).
REQ-018 When both m_cyc are asserted in IDLE, the master not granted last SHALL win (round-robin via last_grant register).
REQ-019 In BUSY, CYC_O, STB_O, WE_O, ADDR_O and DAT_O SHALL be combinational muxes of the granted master's inputs.
REQ-020 In BUSY, ACK_I SHALL be routed only to m_ack of the granted master, and the other m_ack SHALL be 0.
REQ-021 m_dat_r SHALL equal DAT_I, except on a watchdog termination cycle, when it equals ERR_DATA.
REQ-022 The granted master SHALL keep ownership for any number of transfers while its m_cyc stays high; deassertion returns the FSM to IDLE and updates last_grant.
REQ-023 In IDLE, all slave-side outputs and m_ack SHALL be 0; the FSM takes at least one IDLE cycle between owners.
REQ-024 m_stb asserted without m_cyc SHALL be ignored.

Reset
REQ-025 While reset_n is low: FSM is IDLE; grant, m_ack, CYC_O, STB_O, WE_O, ADDR_O and DAT_O are 0; m_dat_r follows DAT_I; last_grant selects master 1 (master 0 wins the first tie); watchdog counter and err_flag are 0.
REQ-026 Reset asserted mid-transaction SHALL drop CYC_O and STB_O asynchronously; the in-flight transfer is lost and no ack is generated.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN defined SHALL enable the watchdog: a 16-bit counter increments each BUSY cycle with STB_O=1 and ACK_I=0, and clears on ACK_I or when leaving BUSY.
REQ-028 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL pulse m_ack of the owner for 1 cycle, drive ERR_DATA on m_dat_r, set err_flag, and clear the counter.
REQ-029 With WB_ARB_TIMEOUT_EN defined, a set of err_flag SHALL take precedence over err_clr in the same cycle.
REQ-030 With WB_ARB_TIMEOUT_EN undefined, no counter SHALL exist, err_flag SHALL be tied 0, and err_clr SHALL be ignored.

Structure
REQ-031 The arb_state_t enum (IDLE, BUSY) SHALL be placed in vanilla_pkg.
REQ-032 Width macros SHALL come from io_map.svh.
REQ-033 The watchdog SHALL be a sub-module wb_watchdog (counter, compare and fire pulse) that is instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-034 m_cyc=01, m_stb=01, m_addr[0]=5, m_we[0]=0, DAT_I=32'h1234, ACK_I one cycle after STB_O -> CYC_O rises one cycle after the request; m_ack=01; m_dat_r=32'h1234; grant=01.
REQ-035 m_cyc=11 from reset -> grant=01; after master 0 releases, one IDLE cycle, then grant=10; repeat both requesting -> grant alternates.
REQ-036 Master 1 owns the bus and holds m_cyc for 3 writes while m_cyc[0]=1 -> grant stays 10 for all 3; m_ack[0] stays 0; master 0 is granted after release.
REQ-037 With WB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, STB_O held and ACK_I=0 -> m_ack pulse at stall cycle 8 with m_dat_r=32'hDEAD_BEEF; err_flag=1 until err_clr.
REQ-038 reset_n low during BUSY -> CYC_O=0 immediately; after release, grant=00; m_cyc=11 then yields grant=01.
